// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size type, memory geometry constants and byte-lane mask helper
package mem_pkg;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11} size_e;
  localparam int WORD_BYTES = 4;
  localparam int DEF_DEPTH = 64000;
  function automatic logic [3:0] lane_mask(size_e sz, logic [1:0] off);
    return sz == SZ_B ? 4'b0001 << off : sz == SZ_H ? 4'b0011 << off : sz == SZ_W ? 4'b1111 << off : 4'b0000;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane replication and byte mask, load lane extraction and sign/zero extension
import mem_pkg::*;
module mem_lane_align (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        unsgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  bmask,
  output logic [31:0] load_data
);
  size_e sz;
  logic [7:0] b;
  logic [15:0] h;
  assign sz = size_e'(size);
  // Replicate store data into every lane and pick/extend the addressed load lane
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    lane_wdata = sz == SZ_B ? {4{wdata[7:0]}} : sz == SZ_H ? {2{wdata[15:0]}} : wdata;
    bmask = lane_mask(sz, off);
    load_data = sz == SZ_B ? {{24{b[7] & ~unsgn}}, b} : sz == SZ_H ? {{16{h[15] & ~unsgn}}, h} : sz == SZ_W ? rdata : 32'h0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one word memory between fetch and load/store ports
import mem_pkg::*;
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_p0_valid,
  input  logic [ADDR_W-1:0] i_p0_addr,
  output logic              o_p0_ready,
  output logic              o_p0_rvalid,
  output logic [31:0]       o_p0_rdata,
  output logic              o_p0_err,
  input  logic              i_p1_valid,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic              i_p1_wren,
  input  logic [1:0]        i_p1_size,
  input  logic              i_p1_unsigned,
  input  logic [31:0]       i_p1_wdata,
  output logic              o_p1_ready,
  output logic              o_p1_rvalid,
  output logic [31:0]       o_p1_rdata,
  output logic              o_p1_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);
  logic ptr, gnt0, gnt1, ok0, ok1;
  logic [3:0] mask;
  logic [31:0] load_data;
  size_e sz;
  assign sz = size_e'(i_p1_size);
  function automatic logic in_range(logic [ADDR_W-1:0] a);
    return (a >> 2) < ADDR_W'(DEPTH);
  endfunction
  mem_lane_align u_align (
    .size(i_p1_size),
    .off(i_p1_addr[1:0]),
    .unsgn(i_p1_unsigned),
    .wdata(i_p1_wdata),
    .rdata(i_mem_rdata),
    .lane_wdata(o_mem_wdata),
    .bmask(mask),
    .load_data(load_data)
  );
  // Grant one port per cycle, check legality and drive the memory; nothing is granted while in reset
  always_comb begin
    gnt0 = i_reset_n & i_p0_valid & (~i_p1_valid | ~ptr);
    gnt1 = i_reset_n & i_p1_valid & (~i_p0_valid | ptr);
    ok0 = i_p0_addr[1:0] == 2'b00 && in_range(i_p0_addr);
    ok1 = (sz == SZ_B || (sz == SZ_H && !i_p1_addr[0]) || (sz == SZ_W && i_p1_addr[1:0] == 2'b00)) && in_range(i_p1_addr);
    o_mem_addr = gnt1 ? i_p1_addr >> 2 : gnt0 ? i_p0_addr >> 2 : '0;
    o_mem_wren = gnt1 & i_p1_wren & ok1;
    o_mem_bmask = o_mem_wren ? mask : 4'b0000;
  end
  assign o_p0_ready = gnt0;
  assign o_p1_ready = gnt1;
  // Priority pointer: a contended grant hands priority to the port that lost
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) ptr <= 1'b0;
    else if (i_p0_valid & i_p1_valid) ptr <= ~ptr;
  // Responses one cycle after grant; rdata holds between grants, illegal or store responses return 0
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      o_p0_rvalid <= 1'b0;
      o_p0_err <= 1'b0;
      o_p0_rdata <= '0;
      o_p1_rvalid <= 1'b0;
      o_p1_err <= 1'b0;
      o_p1_rdata <= '0;
    end else begin
      o_p0_rvalid <= gnt0;
      o_p0_err <= gnt0 & ~ok0;
      if (gnt0) o_p0_rdata <= ok0 ? i_mem_rdata : 32'h0;
      o_p1_rvalid <= gnt1;
      o_p1_err <= gnt1 & ~ok1;
      if (gnt1) o_p1_rdata <= (ok1 & ~i_p1_wren) ? load_data : 32'h0;
    end
endmodule
